// File: rtl/lcd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lcd_ctrl                                                   |
// | Description : HD44780-compatible 16x2 character LCD driver, 8-bit,       |
// |               write-only. Runs the power-on init sequence once, then     |
// |               refreshes both display lines from an external string ROM.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   1  system clock                                         |
// |   rst        in   1  synchronous, active-high reset                       |
// |   char_in    in   8  ASCII byte from the string ROM (1-cycle latency)     |
// |   refresh    in   1  start next frame (only with LCD_FRAME_SYNC_EN)       |
// |   index      out  5  character position, 0-15 line 1, 16-31 line 2       |
// |   lcd_e      out  1  LCD enable strobe                                   |
// |   lcd_rs     out  1  0 = command, 1 = data                               |
// |   lcd_rw     out  1  always 0 (write only)                               |
// |   lcd_data   out  8  LCD DB[7:0]                                         |
// |   init_done  out  1  high once the init sequence has completed           |
// |   frame_done out  1  one-cycle pulse at the end of each frame            |
// | Build option                                                             |
// |   LCD_FRAME_SYNC_EN : when defined, adds the refresh input and parks the |
// |                       FSM in IDLE after every frame until refresh=1.     |
// |                       Undefined (default): free-running refresh.         |
// +--------------------------------------------------------------------------+
module lcd_ctrl #(
  parameter int unsigned INIT_WAIT = 750000,
  parameter int unsigned T_SU      = 4,
  parameter int unsigned E_PULSE   = 12,
  parameter int unsigned CMD_WAIT  = 2500,
  parameter int unsigned CLR_WAIT  = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
`ifdef LCD_FRAME_SYNC_EN
  input  logic       refresh,
`endif
  output logic [4:0] index,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One shared counter covers every delay; it only ever counts up to
  // (largest delay - 1), so $clog2 of the largest delay is enough bits.
  localparam int unsigned CNT_MAX = max_of(max_of(max_of(INIT_WAIT, T_SU),
                                                  max_of(E_PULSE, CMD_WAIT)),
                                           CLR_WAIT);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0] SU_LAST    = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0] EP_LAST    = CNT_W'(E_PULSE - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT - 1);
  // char_in reflects the new index one cycle after SETUP entry, so it is
  // captured at the end of SETUP cycle 1.
  localparam logic [CNT_W-1:0] DATA_LATCH = CNT_W'(1);

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // auto-increment, no shift
  localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display (long execution)
  localparam logic [7:0] CMD_ADDR1    = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] CMD_ADDR2    = 8'hC0;  // DDRAM address 0x40

  localparam logic [4:0] LINE1_LAST = 5'd15;
  localparam logic [4:0] LINE2_FIRST = 5'd16;
  localparam logic [4:0] LINE2_LAST = 5'd31;

  typedef enum logic [3:0] {
    S_PWR_WAIT = 4'd0,
    S_FUNC_SET = 4'd1,
    S_DISP_ON  = 4'd2,
    S_ENTRY    = 4'd3,
    S_CLEAR    = 4'd4,
    S_ADDR1    = 4'd5,
    S_LINE1    = 4'd6,
    S_ADDR2    = 4'd7,
    S_LINE2    = 4'd8,
    S_IDLE     = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    P_SETUP = 2'd0,
    P_EHIGH = 2'd1,
    P_WAIT  = 2'd2
  } phase_t;

  state_t           r_state;
  phase_t           r_phase;
  logic [CNT_W-1:0] r_cnt;

  // Successor of the current step: what the next byte is (or IDLE).
  state_t           w_nxt_state;
  logic             w_nxt_is_byte;
  logic             w_nxt_is_data;
  logic [7:0]       w_nxt_cmd;
  logic [4:0]       w_nxt_index;
  logic             w_end_of_frame;
  logic [CNT_W-1:0] w_wait_last;

  assign w_wait_last = (r_state == S_CLEAR) ? CLR_LAST : CMD_LAST;

  always_comb begin
    w_nxt_state    = S_PWR_WAIT;
    w_nxt_is_byte  = 1'b1;
    w_nxt_is_data  = 1'b0;
    w_nxt_cmd      = 8'h00;
    w_nxt_index    = index;
    w_end_of_frame = 1'b0;
    case (r_state)
      S_PWR_WAIT: begin
        w_nxt_state = S_FUNC_SET;
        w_nxt_cmd   = CMD_FUNC_SET;
      end
      S_FUNC_SET: begin
        w_nxt_state = S_DISP_ON;
        w_nxt_cmd   = CMD_DISP_ON;
      end
      S_DISP_ON: begin
        w_nxt_state = S_ENTRY;
        w_nxt_cmd   = CMD_ENTRY;
      end
      S_ENTRY: begin
        w_nxt_state = S_CLEAR;
        w_nxt_cmd   = CMD_CLEAR;
      end
      S_CLEAR: begin
        w_nxt_state = S_ADDR1;
        w_nxt_cmd   = CMD_ADDR1;
      end
      S_ADDR1: begin
        w_nxt_state   = S_LINE1;
        w_nxt_is_data = 1'b1;
        w_nxt_index   = 5'd0;
      end
      S_LINE1: begin
        if (index == LINE1_LAST) begin
          w_nxt_state = S_ADDR2;
          w_nxt_cmd   = CMD_ADDR2;
        end else begin
          w_nxt_state   = S_LINE1;
          w_nxt_is_data = 1'b1;
          w_nxt_index   = index + 5'd1;
        end
      end
      S_ADDR2: begin
        w_nxt_state   = S_LINE2;
        w_nxt_is_data = 1'b1;
        w_nxt_index   = LINE2_FIRST;
      end
      S_LINE2: begin
        if (index == LINE2_LAST) begin
          w_end_of_frame = 1'b1;
`ifdef LCD_FRAME_SYNC_EN
          w_nxt_state    = S_IDLE;
          w_nxt_is_byte  = 1'b0;
`else
          w_nxt_state    = S_ADDR1;
          w_nxt_cmd      = CMD_ADDR1;
`endif
        end else begin
          w_nxt_state   = S_LINE2;
          w_nxt_is_data = 1'b1;
          w_nxt_index   = index + 5'd1;
        end
      end
      S_IDLE: begin
        w_nxt_state = S_ADDR1;
        w_nxt_cmd   = CMD_ADDR1;
      end
      default: begin
        w_nxt_state   = S_PWR_WAIT;
        w_nxt_is_byte = 1'b0;
      end
    endcase
  end

  // Go-to-next-step request, raised where the current step is complete.
  logic w_advance;

  always_comb begin
    w_advance = 1'b0;
    case (r_state)
      S_PWR_WAIT: w_advance = (r_cnt == INIT_LAST);
`ifdef LCD_FRAME_SYNC_EN
      S_IDLE:     w_advance = refresh;
`else
      S_IDLE:     w_advance = 1'b1;
`endif
      default:    w_advance = (r_phase == P_WAIT) && (r_cnt == w_wait_last);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_PWR_WAIT;
      r_phase    <= P_SETUP;
      r_cnt      <= '0;
      index      <= 5'd0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_rw     <= 1'b0;
      lcd_data   <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      lcd_rw     <= 1'b0;
      frame_done <= 1'b0;

      if (w_advance) begin
        // Start the next step; every byte begins in SETUP with E low.
        r_state    <= w_nxt_state;
        r_phase    <= P_SETUP;
        r_cnt      <= '0;
        lcd_e      <= 1'b0;
        index      <= w_nxt_index;
        frame_done <= w_end_of_frame;
        if (r_state == S_CLEAR) begin
          init_done <= 1'b1;
        end
        // Entering IDLE leaves RS/DB untouched so the bus stays quiet.
        if (w_nxt_is_byte) begin
          lcd_rs <= w_nxt_is_data;
          if (!w_nxt_is_data) begin
            lcd_data <= w_nxt_cmd;
          end
        end
      end else if (r_state == S_PWR_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state != S_IDLE) begin
        case (r_phase)
          P_SETUP: begin
            // Only data bytes have RS high during SETUP.
            if (lcd_rs && (r_cnt == DATA_LATCH)) begin
              lcd_data <= char_in;
            end
            if (r_cnt == SU_LAST) begin
              r_phase <= P_EHIGH;
              r_cnt   <= '0;
              lcd_e   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          P_EHIGH: begin
            if (r_cnt == EP_LAST) begin
              r_phase <= P_WAIT;
              r_cnt   <= '0;
              lcd_e   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          P_WAIT: begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          default: begin
            r_phase <= P_WAIT;
            r_cnt   <= '0;
            lcd_e   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
